// File: rtl/axi4_lite_read_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_read_arbiter_pkg
// Brief    : Shared types and bounds for the AXI4-Lite read arbiter.
// Revision : 1.0
// ============================================================================
package axi4_lite_read_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_e;

    localparam int MAXLIMITOF_OUTSTANDINGTX = 10;

endpackage : axi4_lite_read_arbiter_pkg
`default_nettype wire

// File: rtl/axi4_lite_read_order_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_read_order_fifo
// Brief    : Small synchronous FIFO holding the owner index of each read in flight.
// Revision : 1.0
// ============================================================================
module axi4_lite_read_order_fifo #(
    parameter  int WIDTH = 1,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= inc_ptr(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_q <= inc_ptr(rd_ptr_q);
            end
            if (w_push && !w_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule : axi4_lite_read_order_fifo
`default_nettype wire

// File: rtl/axi4_lite_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_read_arbiter
// Brief    : Round-robin AR arbiter with in-order R routing for N AXI4-Lite readers.
// Revision : 1.0
// ============================================================================
module axi4_lite_read_arbiter
    import axi4_lite_read_arbiter_pkg::*;
#(
    parameter  int NO_OF_REQUESTERS = 2,
    parameter  int ADDRESS_WIDTH    = 32,
    parameter  int DATA_WIDTH       = 32,
    parameter  int MAX_OUTSTANDING  = 4,
    localparam int IDX_W            = $clog2(NO_OF_REQUESTERS),
    localparam int CNT_W            = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                      aclk,
    input  logic                                      aresetn,
    input  logic [NO_OF_REQUESTERS-1:0]               s_arvalid,
    output logic [NO_OF_REQUESTERS-1:0]               s_arready,
    input  logic [NO_OF_REQUESTERS*ADDRESS_WIDTH-1:0] s_araddr,
    input  logic [NO_OF_REQUESTERS*3-1:0]             s_arprot,
    output logic [NO_OF_REQUESTERS-1:0]               s_rvalid,
    input  logic [NO_OF_REQUESTERS-1:0]               s_rready,
    output logic [DATA_WIDTH-1:0]                     s_rdata,
    output logic [1:0]                                s_rresp,
    output logic                                      m_arvalid,
    input  logic                                      m_arready,
    output logic [ADDRESS_WIDTH-1:0]                  m_araddr,
    output logic [2:0]                                m_arprot,
    input  logic                                      m_rvalid,
    output logic                                      m_rready,
    input  logic [DATA_WIDTH-1:0]                     m_rdata,
    input  logic [1:0]                                m_rresp,
    output logic [CNT_W-1:0]                          outstanding_cnt,
    output logic                                      err_unexpected_r
);

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > MAXLIMITOF_OUTSTANDINGTX) begin : g_bad_depth
        $error("MAX_OUTSTANDING out of range");
    end

    arb_state_e               state_q, state_d;
    logic [IDX_W-1:0]         last_grant_q, last_grant_d;
    logic [ADDRESS_WIDTH-1:0] araddr_q, araddr_d;
    logic [2:0]               arprot_q, arprot_d;
    logic                     err_q;

    logic [IDX_W-1:0]         w_cand;
    logic [IDX_W-1:0]         w_winner;
    logic                     w_found;
    logic                     w_accept;
    logic [IDX_W-1:0]         w_owner;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic                     w_pop;

    // Scan starts one past the last grant so every requester gets a turn.
    always_comb begin
        w_cand   = '0;
        w_winner = '0;
        w_found  = 1'b0;
        for (int k = 1; k <= NO_OF_REQUESTERS; k++) begin
            w_cand = IDX_W'((int'(last_grant_q) + k) % NO_OF_REQUESTERS);
            if (!w_found && s_arvalid[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        araddr_d     = araddr_q;
        arprot_d     = arprot_q;
        w_accept     = 1'b0;
        s_arready    = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (w_found && !w_fifo_full) begin
                    w_accept            = 1'b1;
                    s_arready[w_winner] = 1'b1;
                    araddr_d            = s_araddr[int'(w_winner)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    arprot_d            = s_arprot[int'(w_winner)*3 +: 3];
                    last_grant_d        = w_winner;
                    state_d             = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (m_arready) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= IDX_W'(NO_OF_REQUESTERS - 1);
            araddr_q     <= '0;
            arprot_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            araddr_q     <= araddr_d;
            arprot_q     <= arprot_d;
            if (m_rvalid && w_fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign m_arvalid        = (state_q == ARB_ISSUE);
    assign m_araddr         = araddr_q;
    assign m_arprot         = arprot_q;
    assign err_unexpected_r = err_q;

    // Data and response are broadcast; only the owner sees rvalid.
    always_comb begin
        s_rvalid = '0;
        m_rready = 1'b0;
        if (!w_fifo_empty) begin
            s_rvalid[w_owner] = m_rvalid;
            m_rready          = s_rready[w_owner];
        end
    end

    assign s_rdata = m_rdata;
    assign s_rresp = m_rresp;
    assign w_pop   = m_rvalid & m_rready;

    axi4_lite_read_order_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk         (aclk),
        .rst_n       (aresetn),
        .push_i      (w_accept),
        .push_data_i (w_winner),
        .pop_i       (w_pop),
        .head_o      (w_owner),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .count_o     (outstanding_cnt)
    );

endmodule : axi4_lite_read_arbiter
`default_nettype wire

// File: tb/tb_axi4_lite_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_read_arbiter
// Brief    : Directed self-checking bench for axi4_lite_read_arbiter (N=2, depth 4).
// Revision : 1.0
// ============================================================================
module tb_axi4_lite_read_arbiter;

    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MAX = 4;
    localparam int CW  = $clog2(MAX + 1);

    logic            aclk;
    logic            aresetn;
    logic [N-1:0]    s_arvalid;
    logic [N-1:0]    s_arready;
    logic [N*AW-1:0] s_araddr;
    logic [N*3-1:0]  s_arprot;
    logic [N-1:0]    s_rvalid;
    logic [N-1:0]    s_rready;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            m_arvalid;
    logic            m_arready;
    logic [AW-1:0]   m_araddr;
    logic [2:0]      m_arprot;
    logic            m_rvalid;
    logic            m_rready;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic [CW-1:0]   outstanding_cnt;
    logic            err_unexpected_r;

    int n_checks;
    int n_fail;

    axi4_lite_read_arbiter #(
        .NO_OF_REQUESTERS (N),
        .ADDRESS_WIDTH    (AW),
        .DATA_WIDTH       (DW),
        .MAX_OUTSTANDING  (MAX)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .s_arvalid        (s_arvalid),
        .s_arready        (s_arready),
        .s_araddr         (s_araddr),
        .s_arprot         (s_arprot),
        .s_rvalid         (s_rvalid),
        .s_rready         (s_rready),
        .s_rdata          (s_rdata),
        .s_rresp          (s_rresp),
        .m_arvalid        (m_arvalid),
        .m_arready        (m_arready),
        .m_araddr         (m_araddr),
        .m_arprot         (m_arprot),
        .m_rvalid         (m_rvalid),
        .m_rready         (m_rready),
        .m_rdata          (m_rdata),
        .m_rresp          (m_rresp),
        .outstanding_cnt  (outstanding_cnt),
        .err_unexpected_r (err_unexpected_r)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn   = 1'b0;
        s_arvalid = '0;
        s_araddr  = '0;
        s_arprot  = '0;
        s_rready  = '0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = '0;
        #1;
        chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
        chk("rst_m_araddr", 64'(m_araddr), 64'd0);
        chk("rst_cnt", 64'(outstanding_cnt), 64'd0);
        chk("rst_err", 64'(err_unexpected_r), 64'd0);
        chk("rst_s_arready", 64'(s_arready), 64'd0);
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    // One single-requester AR through IDLE and ISSUE with m_arready already high.
    task automatic issue_one(input int req, input logic [AW-1:0] addr);
        s_arvalid = '0;
        s_arvalid[req] = 1'b1;
        s_araddr[req*AW +: AW] = addr;
        m_arready = 1'b1;
        #1;
        chk("issue_s_arready", 64'(s_arready), 64'(s_arvalid));
        tick();
        s_arvalid = '0;
        #1;
        chk("issue_m_araddr", 64'(m_araddr), 64'(addr));
        tick();
    endtask

    task automatic rsp(input logic [N-1:0] exp_sv, input logic [DW-1:0] data);
        m_rvalid = 1'b1;
        m_rdata  = data;
        s_rready = '1;
        #1;
        chk("rsp_s_rvalid", 64'(s_rvalid), 64'(exp_sv));
        chk("rsp_s_rdata", 64'(s_rdata), 64'(data));
        tick();
        m_rvalid = 1'b0;
    endtask

    initial begin
        int acc;
        n_checks = 0;
        n_fail   = 0;

        // 1: single requester, addr/prot capture and R routing.
        do_reset();
        s_arvalid = 2'b01;
        s_araddr[AW-1:0] = 32'h100;
        s_arprot[2:0] = 3'b101;
        m_arready = 1'b1;
        #1;
        chk("t1_s_arready", 64'(s_arready), 64'h1);
        tick();
        s_arvalid = '0;
        chk("t1_m_arvalid", 64'(m_arvalid), 64'h1);
        chk("t1_m_araddr", 64'(m_araddr), 64'h100);
        chk("t1_m_arprot", 64'(m_arprot), 64'h5);
        chk("t1_cnt", 64'(outstanding_cnt), 64'd1);
        tick();
        chk("t1_m_arvalid_low", 64'(m_arvalid), 64'h0);
        m_rvalid = 1'b1;
        m_rdata  = 32'hCAFE_0001;
        s_rready = 2'b01;
        #1;
        chk("t1_s_rvalid", 64'(s_rvalid), 64'h1);
        chk("t1_m_rready", 64'(m_rready), 64'h1);
        chk("t1_s_rdata", 64'(s_rdata), 64'hCAFE_0001);
        tick();
        m_rvalid = 1'b0;
        chk("t1_cnt_after", 64'(outstanding_cnt), 64'd0);

        // 2: both requesting continuously -> grants 0,1,0,1.
        do_reset();
        s_araddr  = {32'h300, 32'h200};
        s_arvalid = 2'b11;
        m_arready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (k % 2 == 0) begin
                chk("t2_grant", 64'(s_arready), ((k / 2) % 2 == 0) ? 64'h1 : 64'h2);
            end else begin
                chk("t2_no_grant", 64'(s_arready), 64'h0);
                chk("t2_m_araddr", 64'(m_araddr), ((k / 2) % 2 == 0) ? 64'h200 : 64'h300);
            end
            tick();
        end
        s_arvalid = '0;
        chk("t2_cnt", 64'(outstanding_cnt), 64'd4);
        rsp(2'b01, 32'hA0);
        rsp(2'b10, 32'hA1);
        rsp(2'b01, 32'hA2);
        rsp(2'b10, 32'hA3);
        chk("t2_cnt_drained", 64'(outstanding_cnt), 64'd0);

        // 3: responses held off -> accepts stop at MAX until one pop.
        do_reset();
        s_arvalid = 2'b01;
        s_araddr[AW-1:0] = 32'h400;
        m_arready = 1'b1;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (s_arready[0]) acc++;
            tick();
        end
        chk("t3_accepted", 64'(acc), 64'd4);
        chk("t3_cnt_full", 64'(outstanding_cnt), 64'd4);
        chk("t3_arready_full", 64'(s_arready), 64'h0);
        m_rvalid = 1'b1;
        s_rready = 2'b01;
        #1;
        chk("t3_pop_s_rvalid", 64'(s_rvalid), 64'h1);
        chk("t3_pop_no_arready", 64'(s_arready), 64'h0);
        tick();
        m_rvalid = 1'b0;
        #1;
        chk("t3_cnt_after_pop", 64'(outstanding_cnt), 64'd3);
        chk("t3_fifth_arready", 64'(s_arready), 64'h1);
        tick();
        s_arvalid = '0;
        chk("t3_cnt_refull", 64'(outstanding_cnt), 64'd4);
        tick();
        for (int k = 0; k < 4; k++) rsp(2'b01, 32'(k));
        chk("t3_cnt_drained", 64'(outstanding_cnt), 64'd0);

        // 4: downstream AR stall holds the issued request stable.
        do_reset();
        s_arvalid = 2'b10;
        s_araddr  = {32'hA00, 32'hB00};
        m_arready = 1'b0;
        #1;
        chk("t4_s_arready", 64'(s_arready), 64'h2);
        tick();
        s_arvalid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_stall_arvalid", 64'(m_arvalid), 64'h1);
            chk("t4_stall_araddr", 64'(m_araddr), 64'hA00);
            chk("t4_stall_arready", 64'(s_arready), 64'h0);
            tick();
        end
        m_arready = 1'b1;
        s_arvalid = '0;
        tick();
        chk("t4_arvalid_drop", 64'(m_arvalid), 64'h0);
        rsp(2'b10, 32'hB4);

        // 5: push and pop in the same cycle at cnt=2.
        do_reset();
        issue_one(0, 32'h500);
        issue_one(1, 32'h600);
        chk("t5_cnt2", 64'(outstanding_cnt), 64'd2);
        s_arvalid = 2'b01;
        s_araddr[AW-1:0] = 32'h700;
        m_rvalid = 1'b1;
        m_rdata  = 32'h55;
        s_rready = 2'b11;
        #1;
        chk("t5_s_rvalid", 64'(s_rvalid), 64'h1);
        chk("t5_s_arready", 64'(s_arready), 64'h1);
        tick();
        s_arvalid = '0;
        m_rvalid  = 1'b0;
        chk("t5_cnt_same", 64'(outstanding_cnt), 64'd2);
        tick();
        rsp(2'b10, 32'h66);
        rsp(2'b01, 32'h77);
        chk("t5_cnt_drained", 64'(outstanding_cnt), 64'd0);

        // 6: unexpected R, sticky error, then reset while in ISSUE.
        do_reset();
        m_rvalid = 1'b1;
        s_rready = 2'b11;
        #1;
        chk("t6_m_rready", 64'(m_rready), 64'h0);
        chk("t6_s_rvalid", 64'(s_rvalid), 64'h0);
        tick();
        m_rvalid = 1'b0;
        chk("t6_err_set", 64'(err_unexpected_r), 64'h1);
        tick();
        chk("t6_err_sticky", 64'(err_unexpected_r), 64'h1);
        m_arready = 1'b0;
        s_arvalid = 2'b01;
        s_araddr[AW-1:0] = 32'h900;
        tick();
        s_arvalid = '0;
        chk("t6_issue_arvalid", 64'(m_arvalid), 64'h1);
        chk("t6_issue_araddr", 64'(m_araddr), 64'h900);
        aresetn  = 1'b0;
        m_rvalid = 1'b1;
        #1;
        chk("t6_rst_arvalid", 64'(m_arvalid), 64'h0);
        chk("t6_rst_araddr", 64'(m_araddr), 64'h0);
        chk("t6_rst_cnt", 64'(outstanding_cnt), 64'd0);
        chk("t6_rst_err", 64'(err_unexpected_r), 64'h0);
        chk("t6_rst_s_rvalid", 64'(s_rvalid), 64'h0);
        chk("t6_rst_m_rready", 64'(m_rready), 64'h0);
        tick();
        aresetn = 1'b1;
        tick();
        chk("t6_post_s_rvalid", 64'(s_rvalid), 64'h0);
        chk("t6_post_m_rready", 64'(m_rready), 64'h0);
        m_rvalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_axi4_lite_read_arbiter
`default_nettype wire
